sort4_seq: RTL and testbench

- Sequential bubble-sort controller built around one shared 4-bit magnitude comparator.
- Captures N unsigned 4-bit elements and sorts them ascending, issuing one comparison per clock.
- Uses early termination and reports the number of swaps performed.
- Sits above the comp4bit datapath block and is the lab's first sequenced use of the comparator.

---
 rtl/sort4_seq_pkg.sv | 8 +
 rtl/sort4_seq_if.sv | 13 +
 rtl/sort4_seq_comp4bit.sv | 12 +
 rtl/sort4_seq.sv | 89 ++++++++
 tb/tb_sort4_seq.sv | 102 ++++++++++
 5 files changed

// File: rtl/sort4_seq_pkg.sv
// sort4_seq_pkg: shared state encoding, element width and swap-counter sizing
package sort4_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, DONE = 2'd2} state_t;
    localparam int W = 4;
    function automatic int scw(input int n);
        return $clog2(n * (n - 1) / 2 + 1);
    endfunction
endpackage

// File: rtl/sort4_seq_if.sv
// sort4_seq_if: start/data request and sorted-result bundle for sort4_seq
interface sort4_seq_if #(parameter int N = 4);
    import sort4_seq_pkg::*;
    localparam int SCW = scw(N);
    logic           start;
    logic [N*W-1:0] data_in;
    logic           busy;
    logic           done;
    logic [N*W-1:0] data_out;
    logic [SCW-1:0] swap_count;
    modport master(output start, data_in, input busy, done, data_out, swap_count);
    modport slave(input start, data_in, output busy, done, data_out, swap_count);
endinterface

// File: rtl/sort4_seq_comp4bit.sv
// comp4bit: unsigned 4-bit magnitude comparator
module comp4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       agtb,
    output logic       aeqb,
    output logic       altb
);
    assign agtb = a > b;
    assign aeqb = a == b;
    assign altb = a < b;
endmodule

// File: rtl/sort4_seq.sv
// sort4_seq: stable bubble sort of N 4-bit elements, one shared comparison per clock,
// with early termination and a swap count
module sort4_seq
    import sort4_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rst,
    sort4_seq_if.slave bus
);
    localparam int SCW = scw(N);
    localparam int JW = $clog2(N);
    localparam logic [JW-1:0] LAST = JW'(N - 2);
    state_t         r_state, w_next;
    logic [W-1:0]   r_el [N];
    logic [W-1:0]   w_el [N];
    logic [JW-1:0]  r_j, r_pass, w_j1;
    logic           r_swapped, w_agtb, w_last, w_swapped, w_more;
    logic           w_unused_eq, w_unused_lt;
    logic [SCW-1:0] r_cnt, w_cnt, r_swap_count;
    logic [N*W-1:0] r_data_out, w_packed;

    assign w_j1 = r_j + 1'b1;

    comp4bit u_cmp (
        .a    (r_el[r_j]),
        .b    (r_el[w_j1]),
        .agtb (w_agtb),
        .aeqb (w_unused_eq),
        .altb (w_unused_lt)
    );

    // pass p ends at j = N-2-p; another pass only if something moved and passes remain
    assign w_last    = (r_j + r_pass) >= LAST;
    assign w_swapped = r_swapped | w_agtb;
    assign w_more    = w_swapped && (r_pass < LAST);
    assign w_cnt     = r_cnt + SCW'(w_agtb);

    always_comb begin
        w_el = r_el;
        w_el[r_j]  = w_agtb ? r_el[w_j1] : r_el[r_j];
        w_el[w_j1] = w_agtb ? r_el[r_j] : r_el[w_j1];
        for (int k = 0; k < N; k++) w_packed[k*W +: W] = w_el[k];
    end

    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = (r_state == IDLE) ? (bus.start ? CMP : IDLE) :
                 (r_state == CMP)  ? ((w_last && !w_more) ? DONE : CMP) : IDLE;
    end

    always_comb begin
        bus.busy       = r_state == CMP;
        bus.done       = r_state == DONE;
        bus.data_out   = r_data_out;
        bus.swap_count = r_swap_count;
    end

    // results are latched on the final comparison so they are valid during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) r_el[k] <= '0;
            r_j          <= '0;
            r_pass       <= '0;
            r_swapped    <= 1'b0;
            r_cnt        <= '0;
            r_data_out   <= '0;
            r_swap_count <= '0;
        end else if (r_state == IDLE && bus.start) begin
            for (int k = 0; k < N; k++) r_el[k] <= bus.data_in[k*W +: W];
            r_j       <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
            r_cnt     <= '0;
        end else if (r_state == CMP) begin
            r_el      <= w_el;
            r_cnt     <= w_cnt;
            r_j       <= w_last ? '0 : w_j1;
            r_pass    <= (w_last && w_more) ? r_pass + 1'b1 : r_pass;
            r_swapped <= w_last ? 1'b0 : w_swapped;
            if (w_last && !w_more) begin
                r_data_out   <= w_packed;
                r_swap_count <= w_cnt;
            end
        end
    end
endmodule

// File: tb/tb_sort4_seq.sv
// tb_sort4_seq: directed and random sorts checked cycle by cycle against an
// inversion-count model of bubble sort
module tb_sort4_seq;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sort4_seq_if #(.N(N)) bus ();

    sort4_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // swaps = inversions; swapping passes = max count of larger elements left of any element
    function automatic void model(input logic [15:0] d, output logic [15:0] so,
                                  output int sw, output int c);
        int v[N];
        int q[$];
        int p, inv, passes;
        for (int k = 0; k < N; k++) v[k] = int'(d[k*4 +: 4]);
        sw = 0;
        p  = 0;
        for (int k = 0; k < N; k++) begin
            inv = 0;
            for (int i = 0; i < k; i++) if (v[i] > v[k]) inv++;
            sw += inv;
            if (inv > p) p = inv;
        end
        for (int val = 0; val < 16; val++)
            for (int k = 0; k < N; k++) if (v[k] == val) q.push_back(val);
        so = '0;
        for (int k = 0; k < N; k++) so[k*4 +: 4] = 4'(q[k]);
        passes = (p + 1 < N - 1) ? p + 1 : N - 1;
        c = 0;
        for (int i = 0; i < passes; i++) c += N - 1 - i;
    endfunction

    task automatic run(input logic [15:0] d, input bit repulse, input string tag);
        logic [15:0] so;
        int sw, c;
        model(d, so, sw, c);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = d;
        for (int cyc = 1; cyc <= c + 2; cyc++) begin
            @(negedge clk);
            bus.start   = repulse && cyc == 3;
            bus.data_in = (repulse && cyc == 3) ? 16'h1111 : d;
            chk({tag, " busy"}, 32'(bus.busy), 32'(cyc <= c));
            chk({tag, " done"}, 32'(bus.done), 32'(cyc == c + 1));
            if (cyc >= c + 1) begin
                chk({tag, " data_out"}, 32'(bus.data_out), 32'(so));
                chk({tag, " swap_count"}, 32'(bus.swap_count), 32'(sw));
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset data_out", 32'(bus.data_out), 0);
        chk("reset swap_count", 32'(bus.swap_count), 0);
        rst = 1'b0;
        run(16'h4321, 1'b0, "sorted");
        run(16'h3579, 1'b0, "reversed");
        run(16'h5355, 1'b0, "dups");
        run(16'h3579, 1'b1, "repulse");
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 16'h3579;
        repeat (3) @(negedge clk) bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 32'(bus.busy), 0);
        chk("midrst done", 32'(bus.done), 0);
        chk("midrst data_out", 32'(bus.data_out), 0);
        chk("midrst swap_count", 32'(bus.swap_count), 0);
        @(negedge clk);
        chk("midrst no done", 32'(bus.done), 0);
        run(16'h2143, 1'b0, "after_rst");
        for (int t = 0; t < 20; t++) run(16'($urandom), 1'b0, "random");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
